// File: rtl/multi_mode_counter.sv
// multi_mode_counter: registered binary/Gray/ring/Johnson counter with clear, load, enable, tc and wrap flags
// Ports: clk rising edge; rst async active-low; en count enable; clr sync clear to the mode's initial value;
//   load/load_val sync parallel load; up_dn 1=up/left 0=down/right; mode 00 bin 01 Gray 10 ring 11 Johnson;
//   sat binary saturate; q count/pattern; tc next enabled step wraps (comb); wrap one-cycle pulse after a wrap step
module multi_mode_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  localparam logic [1:0] M_BIN = 2'b00;
  localparam logic [1:0] M_GRAY = 2'b01;
  localparam logic [1:0] M_RING = 2'b10;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
  logic [WIDTH-1:0] q_q, q_d, cnt_q, cnt_d, cnt_nx, bin_nx, ring_nx, john_nx, step_nx, init;
  logic [1:0] mode_q, mode_d;
  logic wrap_q, wrap_d, reload, at_end;
  // cnt is the binary image behind the Gray code; q is the state for every other mode
  always_comb begin
    reload = clr || (mode != mode_q);
    init = (mode == M_RING) ? ONE : '0;
    cnt_nx = up_dn ? cnt_q + ONE : cnt_q - ONE;
    bin_nx = up_dn ? ((q_q == MAX) ? (sat ? q_q : '0) : q_q + ONE)
                   : ((q_q == '0) ? (sat ? q_q : MAX) : q_q - ONE);
    ring_nx = up_dn ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} : {q_q[0], q_q[WIDTH-1:1]};
    john_nx = up_dn ? {q_q[WIDTH-2:0], ~q_q[WIDTH-1]} : {~q_q[0], q_q[WIDTH-1:1]};
    step_nx = (mode_q == M_BIN) ? bin_nx
            : (mode_q == M_GRAY) ? (cnt_nx ^ (cnt_nx >> 1))
            : (mode_q == M_RING) ? ring_nx : john_nx;
    at_end = (mode_q == M_BIN) ? (up_dn ? (q_q == MAX) : (q_q == '0))
           : (mode_q == M_GRAY) ? (up_dn ? (&cnt_q) : (cnt_q == '0))
           : (up_dn ? (q_q == MSB) : (q_q == ONE));
    tc = en && !reload && !load && at_end;
    mode_d = mode;
    q_d = reload ? init
        : load ? ((mode_q == M_BIN) ? ((load_val > MAX) ? MAX : load_val)
                : (mode_q == M_GRAY) ? (load_val ^ (load_val >> 1)) : load_val)
        : en ? step_nx : q_q;
    cnt_d = reload ? '0 : load ? load_val : (en && mode_q == M_GRAY) ? cnt_nx : cnt_q;
    // a saturating binary end step holds, so it is not a wrap
    wrap_d = tc && !(mode_q == M_BIN && sat);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q_q <= '0;
      cnt_q <= '0;
      mode_q <= M_BIN;
      wrap_q <= 1'b0;
    end else begin
      q_q <= q_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
    end
  assign q = q_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_multi_mode_counter.sv
// tb_multi_mode_counter: scoreboard bench for multi_mode_counter (WIDTH=4, MODULUS=10)
module tb_multi_mode_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic load = 1'b0;
  logic up_dn = 1'b1;
  logic sat = 1'b0;
  logic [3:0] load_val = '0;
  logic [1:0] mode = 2'b00;
  logic [3:0] q;
  logic tc, wrap;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] q_sb[$];
  logic w_sb[$];
  typedef struct {
    logic e, c, l;
    logic [3:0] lv;
    logic u;
    logic [1:0] m;
    logic s, tce;
    logic [3:0] qe;
    logic we;
  } step_t;

  multi_mode_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .mode(mode), .sat(sat), .q(q), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic e, c, l, input logic [3:0] lv, input logic u,
                               input logic [1:0] m, input logic s, tce, input logic [3:0] qe, input logic we);
    step_t r;
    r.e = e; r.c = c; r.l = l; r.lv = lv; r.u = u; r.m = m; r.s = s; r.tce = tce; r.qe = qe; r.we = we;
    return r;
  endfunction

  task automatic pulse_rst;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    en = 1'b1;
    #2;
    n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL reset_q got %b want 0000", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b want 0", wrap); end
    n_cmp++; if (tc !== 1'b0) begin n_bad++; $display("FAIL reset_tc got %b want 0", tc); end
    @(posedge clk); #1;
    n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL reset_hold_q got %b want 0000", q); end
    rst = 1'b1;
  endtask

  task automatic test_bin_up;
    step_t s[$];
    logic [3:0] qe;
    logic we;
    for (int i = 0; i < 12; i++) s.push_back(mk(1, 0, 0, 0, 1, 0, 0, i == 9, 4'((i + 1) % 10), i == 9));
    s.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    foreach (s[i]) begin
      en = s[i].e; clr = s[i].c; load = s[i].l; load_val = s[i].lv; up_dn = s[i].u; mode = s[i].m; sat = s[i].s;
      q_sb.push_back(s[i].qe); w_sb.push_back(s[i].we);
      #1;
      n_cmp++; if (tc !== s[i].tce) begin n_bad++; $display("FAIL bin_up_tc[%0d] got %b want %b", i, tc, s[i].tce); end
      @(posedge clk); #1;
      qe = q_sb.pop_front(); we = w_sb.pop_front();
      n_cmp++; if (q !== qe) begin n_bad++; $display("FAIL bin_up_q[%0d] got %0d want %0d", i, q, qe); end
      n_cmp++; if (wrap !== we) begin n_bad++; $display("FAIL bin_up_wrap[%0d] got %b want %b", i, wrap, we); end
    end
  endtask

  task automatic test_bin_sat;
    step_t s[$];
    logic [3:0] qe;
    logic we;
    s.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    s.push_back(mk(1, 0, 1, 15, 0, 0, 1, 0, 9, 0));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 8, 0));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 7, 0));
    s.push_back(mk(1, 0, 1, 5, 1, 0, 1, 0, 5, 0));
    s.push_back(mk(1, 0, 1, 12, 1, 0, 1, 0, 9, 0));
    s.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 9, 0));
    s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 9, 1));
    foreach (s[i]) begin
      en = s[i].e; clr = s[i].c; load = s[i].l; load_val = s[i].lv; up_dn = s[i].u; mode = s[i].m; sat = s[i].s;
      q_sb.push_back(s[i].qe); w_sb.push_back(s[i].we);
      #1;
      n_cmp++; if (tc !== s[i].tce) begin n_bad++; $display("FAIL bin_sat_tc[%0d] got %b want %b", i, tc, s[i].tce); end
      @(posedge clk); #1;
      qe = q_sb.pop_front(); we = w_sb.pop_front();
      n_cmp++; if (q !== qe) begin n_bad++; $display("FAIL bin_sat_q[%0d] got %0d want %0d", i, q, qe); end
      n_cmp++; if (wrap !== we) begin n_bad++; $display("FAIL bin_sat_wrap[%0d] got %b want %b", i, wrap, we); end
    end
  endtask

  task automatic test_gray;
    logic [3:0] g[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    step_t s[$];
    logic [3:0] qe, prev;
    logic we;
    pulse_rst();
    for (int k = 0; k < 17; k++) s.push_back(mk(1, 0, 0, 0, 1, 2'b01, 0, k == 16, g[k], k == 16));
    s.push_back(mk(1, 0, 0, 0, 0, 2'b01, 1, 1, 8, 1));
    foreach (s[i]) begin
      en = s[i].e; clr = s[i].c; load = s[i].l; load_val = s[i].lv; up_dn = s[i].u; mode = s[i].m; sat = s[i].s;
      q_sb.push_back(s[i].qe); w_sb.push_back(s[i].we);
      #1;
      prev = q;
      n_cmp++; if (tc !== s[i].tce) begin n_bad++; $display("FAIL gray_tc[%0d] got %b want %b", i, tc, s[i].tce); end
      @(posedge clk); #1;
      qe = q_sb.pop_front(); we = w_sb.pop_front();
      n_cmp++; if (q !== qe) begin n_bad++; $display("FAIL gray_q[%0d] got %b want %b", i, q, qe); end
      n_cmp++; if (wrap !== we) begin n_bad++; $display("FAIL gray_wrap[%0d] got %b want %b", i, wrap, we); end
      if (i >= 1) begin
        n_cmp++;
        if ($countones(q ^ prev) != 1) begin n_bad++; $display("FAIL gray_hamming[%0d] got %b->%b want 1 bit change", i, prev, q); end
      end
    end
  endtask

  task automatic test_ring;
    step_t s[$];
    logic [3:0] qe;
    logic we;
    pulse_rst();
    s.push_back(mk(1, 0, 0, 0, 1, 2'b10, 0, 0, 4'b0001, 0));
    s.push_back(mk(1, 0, 0, 0, 1, 2'b10, 0, 0, 4'b0010, 0));
    s.push_back(mk(1, 0, 0, 0, 1, 2'b10, 0, 0, 4'b0100, 0));
    s.push_back(mk(1, 0, 0, 0, 1, 2'b10, 0, 0, 4'b1000, 0));
    s.push_back(mk(1, 0, 0, 0, 1, 2'b10, 0, 1, 4'b0001, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 2'b10, 0, 1, 4'b1000, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 2'b10, 0, 0, 4'b0100, 0));
    s.push_back(mk(1, 0, 1, 4'b0110, 1, 2'b10, 0, 0, 4'b0110, 0));
    s.push_back(mk(1, 0, 0, 0, 1, 2'b10, 0, 0, 4'b1100, 0));
    foreach (s[i]) begin
      en = s[i].e; clr = s[i].c; load = s[i].l; load_val = s[i].lv; up_dn = s[i].u; mode = s[i].m; sat = s[i].s;
      q_sb.push_back(s[i].qe); w_sb.push_back(s[i].we);
      #1;
      n_cmp++; if (tc !== s[i].tce) begin n_bad++; $display("FAIL ring_tc[%0d] got %b want %b", i, tc, s[i].tce); end
      @(posedge clk); #1;
      qe = q_sb.pop_front(); we = w_sb.pop_front();
      n_cmp++; if (q !== qe) begin n_bad++; $display("FAIL ring_q[%0d] got %b want %b", i, q, qe); end
      n_cmp++; if (wrap !== we) begin n_bad++; $display("FAIL ring_wrap[%0d] got %b want %b", i, wrap, we); end
    end
  endtask

  task automatic test_johnson;
    logic [3:0] j[8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    step_t s[$];
    logic [3:0] qe;
    logic we;
    pulse_rst();
    s.push_back(mk(1, 0, 0, 0, 1, 2'b11, 0, 0, 4'b0000, 0));
    for (int k = 0; k < 8; k++) s.push_back(mk(1, 0, 0, 0, 1, 2'b11, 0, k == 7, j[k], k == 7));
    s.push_back(mk(1, 0, 0, 0, 1, 2'b11, 0, 0, 4'b0001, 0));
    s.push_back(mk(1, 1, 1, 4'b1010, 1, 2'b11, 0, 0, 4'b0000, 0));
    s.push_back(mk(1, 0, 1, 4'b1010, 1, 2'b11, 0, 0, 4'b1010, 0));
    s.push_back(mk(1, 0, 0, 0, 1, 2'b11, 0, 0, 4'b0100, 0));
    s.push_back(mk(1, 0, 1, 4'b0001, 0, 2'b11, 0, 0, 4'b0001, 0));
    s.push_back(mk(1, 0, 0, 0, 0, 2'b11, 0, 1, 4'b0000, 1));
    s.push_back(mk(1, 0, 1, 4'b1111, 0, 2'b10, 0, 0, 4'b0001, 0));
    foreach (s[i]) begin
      en = s[i].e; clr = s[i].c; load = s[i].l; load_val = s[i].lv; up_dn = s[i].u; mode = s[i].m; sat = s[i].s;
      q_sb.push_back(s[i].qe); w_sb.push_back(s[i].we);
      #1;
      n_cmp++; if (tc !== s[i].tce) begin n_bad++; $display("FAIL john_tc[%0d] got %b want %b", i, tc, s[i].tce); end
      @(posedge clk); #1;
      qe = q_sb.pop_front(); we = w_sb.pop_front();
      n_cmp++; if (q !== qe) begin n_bad++; $display("FAIL john_q[%0d] got %b want %b", i, q, qe); end
      n_cmp++; if (wrap !== we) begin n_bad++; $display("FAIL john_wrap[%0d] got %b want %b", i, wrap, we); end
    end
  endtask

  task automatic test_async_reset;
    step_t s[$];
    logic [3:0] qe;
    logic we;
    pulse_rst();
    for (int i = 0; i < 10; i++) s.push_back(mk(1, 0, 0, 0, 1, 0, 0, i == 9, 4'((i + 1) % 10), i == 9));
    foreach (s[i]) begin
      en = s[i].e; clr = s[i].c; load = s[i].l; load_val = s[i].lv; up_dn = s[i].u; mode = s[i].m; sat = s[i].s;
      q_sb.push_back(s[i].qe); w_sb.push_back(s[i].we);
      #1;
      n_cmp++; if (tc !== s[i].tce) begin n_bad++; $display("FAIL arst_tc[%0d] got %b want %b", i, tc, s[i].tce); end
      @(posedge clk); #1;
      qe = q_sb.pop_front(); we = w_sb.pop_front();
      n_cmp++; if (q !== qe) begin n_bad++; $display("FAIL arst_q[%0d] got %0d want %0d", i, q, qe); end
      n_cmp++; if (wrap !== we) begin n_bad++; $display("FAIL arst_wrap[%0d] got %b want %b", i, wrap, we); end
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL arst_wrap_clear got %b want 0", wrap); end
    n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL arst_q_clear got %0d want 0", q); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_sb.push_back(4'(i + 1));
      @(posedge clk); #1;
      qe = q_sb.pop_front();
      n_cmp++; if (q !== qe) begin n_bad++; $display("FAIL arst_pre_q[%0d] got %0d want %0d", i, q, qe); end
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL arst_mid_q got %0d want 0", q); end
    #1;
    rst = 1'b1;
    q_sb.push_back(4'd1);
    @(posedge clk); #1;
    qe = q_sb.pop_front();
    n_cmp++; if (q !== qe) begin n_bad++; $display("FAIL arst_resume_q got %0d want %0d", q, qe); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL arst_resume_wrap got %b want 0", wrap); end
  endtask

  initial begin
    test_reset();
    test_bin_up();
    test_bin_sat();
    test_gray();
    test_ring();
    test_johnson();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
